// File: rtl/sram_pipe_ctrl_if.sv
// Command, read-response and SRAM pad signals of the pipelined SRAM controller.
// slave = the controller itself, master = the client plus SRAM environment.
interface sram_pipe_ctrl_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [DATA_BITS-1:0] cmd_wdata;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [DATA_BITS-1:0] rd_data;

    logic [ADDR_BITS-1:0] pad_addr;
    logic [DATA_BITS-1:0] pad_write_data;
    logic                 pad_write_data_enable;
    logic                 pad_ce_n;
    logic                 pad_we_n;
    logic                 pad_oe_n;
    logic [DATA_BITS-1:0] pad_read_data;
    logic                 pad_read_data_valid;

    // Both cmd_* and rd_* are valid/ready: a transfer happens on a clock edge
    // where valid && ready; valid holds with stable payload until accepted.
    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rd_ready,
        input  pad_read_data, pad_read_data_valid,
        output cmd_ready, rd_valid, rd_data,
        output pad_addr, pad_write_data, pad_write_data_enable,
        output pad_ce_n, pad_we_n, pad_oe_n
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rd_ready,
        output pad_read_data, pad_read_data_valid,
        input  cmd_ready, rd_valid, rd_data,
        input  pad_addr, pad_write_data, pad_write_data_enable,
        input  pad_ce_n, pad_we_n, pad_oe_n
    );
endinterface

// File: rtl/sram_pipe_ctrl.sv
// Pipelined synchronous-SRAM controller: one command per cycle onto registered pads,
// credit-limited reads, bus turnaround on direction change, in-order response FIFO.
module sram_pipe_ctrl #(
    parameter int ADDR_BITS       = 20,
    parameter int DATA_BITS       = 16,
    parameter int READ_LATENCY    = 3,
    parameter int TURNAROUND      = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            reset,
    sram_pipe_ctrl_if.slave bus,
    output logic            busy,
    output logic            err_unexpected
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] MAX_CNT = MAX_OUTSTANDING[CNT_W:0];

    typedef enum logic [1:0] {DRAIN, RUN, TURN} state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_last_dir;
    logic [CNT_W-1:0]     r_inflight;
    logic [CNT_W-1:0]     r_fifo_count;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [DATA_BITS-1:0] r_mem [MAX_OUTSTANDING];
    logic                 r_err;

    logic [ADDR_BITS-1:0] r_pad_addr;
    logic [DATA_BITS-1:0] r_pad_wdata;
    logic                 r_pad_wen;
    logic                 r_pad_ce_n;
    logic                 r_pad_we_n;
    logic                 r_pad_oe_n;

    logic                 w_dir_change;
    logic                 w_credit_ok;
    logic                 w_cmd_ready;
    logic                 w_accept;
    logic                 w_issue_rd;
    logic                 w_rtn_ok;
    logic                 w_rtn_bad;
    logic                 w_rd_valid;
    logic                 w_pop;
    logic [CNT_W:0]       w_used;

    assign w_used       = {1'b0, r_inflight} + {1'b0, r_fifo_count};
    assign w_credit_ok  = w_used < MAX_CNT;
    assign w_dir_change = bus.cmd_valid && (bus.cmd_we != r_last_dir) && (TURNAROUND != 0);
    assign w_cmd_ready  = !reset && (r_state == RUN) && w_credit_ok && !w_dir_change;
    assign w_accept     = bus.cmd_valid && w_cmd_ready;
    assign w_issue_rd   = w_accept && !bus.cmd_we;

    // Returns during DRAIN belong to reads discarded by reset and are silently absorbed.
    assign w_rtn_ok   = bus.pad_read_data_valid && (r_state != DRAIN) && (r_inflight != '0);
    assign w_rtn_bad  = bus.pad_read_data_valid && (r_state != DRAIN) && (r_inflight == '0);
    assign w_rd_valid = !reset && (r_fifo_count != '0);
    assign w_pop      = w_rd_valid && bus.rd_ready;

    assign bus.cmd_ready             = w_cmd_ready;
    assign bus.rd_valid              = w_rd_valid;
    assign bus.rd_data               = r_mem[r_rd_ptr];
    assign bus.pad_addr              = r_pad_addr;
    assign bus.pad_write_data        = r_pad_wdata;
    assign bus.pad_write_data_enable = r_pad_wen;
    assign bus.pad_ce_n              = r_pad_ce_n;
    assign bus.pad_we_n              = r_pad_we_n;
    assign bus.pad_oe_n              = r_pad_oe_n;

    assign busy           = reset || (r_state != RUN) || (r_inflight != '0) || (r_fifo_count != '0);
    assign err_unexpected = r_err;

    // The RUN cycle that detects a direction change is the first idle turnaround
    // cycle; TURN covers the remaining TURNAROUND-1 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= DRAIN;
            r_cnt       <= 4'(READ_LATENCY);
            r_last_dir  <= 1'b0;
            r_pad_addr  <= '0;
            r_pad_wdata <= '0;
            r_pad_wen   <= 1'b0;
            r_pad_ce_n  <= 1'b1;
            r_pad_we_n  <= 1'b1;
            r_pad_oe_n  <= 1'b1;
        end else begin
            case (r_state)
                DRAIN: begin
                    if (r_cnt == 4'd0) r_state <= RUN;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                RUN: begin
                    if (w_accept) begin
                        r_last_dir <= bus.cmd_we;
                    end else if (w_dir_change) begin
                        if (TURNAROUND == 1) begin
                            r_last_dir <= bus.cmd_we;
                        end else begin
                            r_state <= TURN;
                            r_cnt   <= 4'(TURNAROUND - 2);
                        end
                    end
                end
                TURN: begin
                    if (r_cnt == 4'd0) begin
                        r_last_dir <= ~r_last_dir;
                        r_state    <= RUN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= DRAIN;
            endcase

            r_pad_ce_n <= !w_accept;
            r_pad_we_n <= !(w_accept && bus.cmd_we);
            r_pad_oe_n <= !(w_accept && !bus.cmd_we);
            r_pad_wen  <= w_accept && bus.cmd_we;
            if (w_accept)              r_pad_addr  <= bus.cmd_addr;
            if (w_accept && bus.cmd_we) r_pad_wdata <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight   <= '0;
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_err        <= 1'b0;
        end else begin
            case ({w_issue_rd, w_rtn_ok})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            case ({w_rtn_ok, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase
            if (w_rtn_ok)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rtn_bad) r_err    <= 1'b1;
        end
    end

    // Credits bound inflight + occupancy to the depth, so a push never finds the FIFO full.
    always_ff @(posedge clk) begin
        if (w_rtn_ok) r_mem[r_wr_ptr] <= bus.pad_read_data;
    end
endmodule
